// File: rtl/read_reg_pkg.sv
// Shared types and widths for the CPU read-back port of the reg1/reg2/reg3 bank.
package read_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    DRIVE  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DW_DEF = 8;
  localparam int HOLD_W = 4;
  localparam int TO_W   = 8;

endpackage

// File: rtl/read_reg_sync.sv
// One-bit multi-flop synchroniser for the asynchronous CPU strobe and chip selects.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/read_reg.sv
// CPU read-back port: synchronises the read strobe and chip selects, snapshots the
// selected register and drives it with output enable, acknowledge and error pulse.
module read_reg
  import read_reg_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          my_rd,
  input  logic          CS_reg1,
  input  logic          CS_reg2,
  input  logic          CS_reg3,
  input  logic [DW-1:0] reg1,
  input  logic [DW-1:0] reg2,
  input  logic [DW-1:0] reg3,
  output logic [DW-1:0] data_out,
  output logic          data_oe,
  output logic          rd_ack,
  output logic          rd_err
);

  logic            rd_s;
  logic [3:1]      cs_s;
  logic            rd_q_r;
  logic            rise_s;
  logic            rise_r;
  logic            armed_r;
  logic [2:0]      settle_r;
  logic            timeout_s;
  logic [DW-1:0]   snap_s;
  logic            none_s;
  state_t          state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd  (.clk(clk), .rst_n(rst), .d(my_rd),   .q(rd_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs1 (.clk(clk), .rst_n(rst), .d(CS_reg1), .q(cs_s[1]));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs2 (.clk(clk), .rst_n(rst), .d(CS_reg2), .q(cs_s[2]));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs3 (.clk(clk), .rst_n(rst), .d(CS_reg3), .q(cs_s[3]));

  assign rise_s    = rd_s & ~rd_q_r;
  assign timeout_s = (state_r == DRIVE) && rd_s && (to_cnt_r == TO_W'(TIMEOUT - 1));

  // Edge detect; the registered rise aligns SELECT entry with edge SYNC_STAGES+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      rd_q_r <= rd_s;
      rise_r <= rise_s & armed_r;
    end
  end

  // The chain resets to 0, so a strobe held through reset only shows after SYNC_STAGES clocks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_r <= 3'd0;
    end else if (settle_r != 3'(SYNC_STAGES)) begin
      settle_r <= settle_r + 3'd1;
    end
  end

  // Arm once the strobe is seen low; a timeout disarms until the strobe drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_r <= 1'b0;
    end else if (timeout_s) begin
      armed_r <= 1'b0;
    end else if ((settle_r == 3'(SYNC_STAGES)) && !rd_s) begin
      armed_r <= 1'b1;
    end
  end

  // Chip-select priority matches the write path: reg1 > reg2 > reg3
  always_comb begin
    snap_s = '0;
    none_s = 1'b0;
    if (cs_s[1]) begin
      snap_s = reg1;
    end else if (cs_s[2]) begin
      snap_s = reg2;
    end else if (cs_s[3]) begin
      snap_s = reg3;
    end else begin
      none_s = 1'b1;
    end
  end

  // Read sequencer with registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      to_cnt_r   <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      rd_err <= 1'b0;
      case (state_r)
        IDLE: begin
          data_oe <= 1'b0;
          rd_ack  <= 1'b0;
          if (rise_r) begin
            state_r <= SELECT;
          end
        end
        SELECT: begin
          data_out <= snap_s;
          rd_err   <= none_s;
          to_cnt_r <= '0;
          data_oe  <= 1'b1;
          rd_ack   <= 1'b1;
          state_r  <= DRIVE;
        end
        DRIVE: begin
          to_cnt_r <= to_cnt_r + TO_W'(1);
          if (!rd_s) begin
            rd_ack     <= 1'b0;
            hold_cnt_r <= '0;
            state_r    <= HOLD;
          end else if (timeout_s) begin
            rd_err     <= 1'b1;
            rd_ack     <= 1'b0;
            hold_cnt_r <= '0;
            state_r    <= HOLD;
          end
        end
        HOLD: begin
          if (rise_r) begin
            hold_cnt_r <= '0;
            state_r    <= SELECT;
          end else if (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_cnt_r <= '0;
            data_oe    <= 1'b0;
            state_r    <= IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_reg.sv
// Directed self-checking bench for read_reg with default parameters.
module tb_read_reg;

  logic       clk;
  logic       rst;
  logic       my_rd;
  logic       cs1, cs2, cs3;
  logic [7:0] reg1, reg2, reg3;
  logic [7:0] data_out;
  logic       data_oe, rd_ack, rd_err;

  int checks = 0;
  int errors = 0;

  read_reg dut (
    .clk(clk), .rst(rst), .my_rd(my_rd),
    .CS_reg1(cs1), .CS_reg2(cs2), .CS_reg3(cs3),
    .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .data_out(data_out), .data_oe(data_oe), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; my_rd = 1'b0; cs1 = 1'b0; cs2 = 1'b0; cs3 = 1'b0;
    reg1 = 8'h00; reg2 = 8'h00; reg3 = 8'h00;
    idle(3);
    checks++;
    if ({data_out, data_oe, rd_ack, rd_err} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got %h/%b%b%b exp 00/000", data_out, data_oe, rd_ack, rd_err);
    end
    rst = 1'b1;
    idle(8);
    checks++;
    if ({data_out, data_oe, rd_ack, rd_err} !== 11'd0) begin
      errors++; $display("FAIL post_reset_idle got %h/%b%b%b exp 00/000", data_out, data_oe, rd_ack, rd_err);
    end
  endtask

  task automatic test_basic_read();
    logic exp_oe, exp_ack;
    reg2 = 8'hA5; cs2 = 1'b1; my_rd = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      @(negedge clk);
      exp_oe  = (e >= 4 && e <= 15);
      exp_ack = (e >= 4 && e <= 11);
      checks++;
      if (data_oe !== exp_oe) begin
        errors++; $display("FAIL basic_oe e=%0d got %b exp %b", e, data_oe, exp_oe);
      end
      checks++;
      if (rd_ack !== exp_ack) begin
        errors++; $display("FAIL basic_ack e=%0d got %b exp %b", e, rd_ack, exp_ack);
      end
      checks++;
      if (rd_err !== 1'b0) begin
        errors++; $display("FAIL basic_err e=%0d got %b exp 0", e, rd_err);
      end
      if (e >= 4) begin
        checks++;
        if (data_out !== 8'hA5) begin
          errors++; $display("FAIL basic_data e=%0d got %h exp a5", e, data_out);
        end
      end
      if (e == 9) my_rd = 1'b0;
      if (e == 13) reg2 = 8'h5A;
    end
    cs2 = 1'b0;
    idle(4);
  endtask

  task automatic test_priority();
    reg1 = 8'h11; reg3 = 8'h33; cs1 = 1'b1; cs3 = 1'b1; my_rd = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (rd_err !== 1'b0) begin
        errors++; $display("FAIL prio_err e=%0d got %b exp 0", e, rd_err);
      end
      if (e == 4) begin
        checks++;
        if (data_out !== 8'h11) begin
          errors++; $display("FAIL prio_data got %h exp 11", data_out);
        end
        checks++;
        if ({data_oe, rd_ack} !== 2'b11) begin
          errors++; $display("FAIL prio_oe_ack got %b%b exp 11", data_oe, rd_ack);
        end
      end
      if (e == 5) begin
        checks++;
        if ({data_oe, rd_ack} !== 2'b10) begin
          errors++; $display("FAIL prio_hold got %b%b exp 10", data_oe, rd_ack);
        end
      end
      if (e == 9) begin
        checks++;
        if (data_oe !== 1'b0) begin
          errors++; $display("FAIL prio_oe_end got %b exp 0", data_oe);
        end
      end
      if (e == 2) my_rd = 1'b0;
    end
    cs1 = 1'b0; cs3 = 1'b0;
    idle(4);
  endtask

  task automatic test_no_select();
    int err_cnt = 0;
    my_rd = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(negedge clk);
      if (rd_err === 1'b1) err_cnt++;
      if (e == 4) begin
        checks++;
        if ({data_out, data_oe, rd_ack, rd_err} !== {8'h00, 3'b111}) begin
          errors++; $display("FAIL nosel_select got %h/%b%b%b exp 00/111", data_out, data_oe, rd_ack, rd_err);
        end
      end
      if (e == 8) begin
        checks++;
        if ({data_oe, rd_ack} !== 2'b10) begin
          errors++; $display("FAIL nosel_hold got %b%b exp 10", data_oe, rd_ack);
        end
      end
      if (e == 9) begin
        checks++;
        if (data_oe !== 1'b0) begin
          errors++; $display("FAIL nosel_oe_end got %b exp 0", data_oe);
        end
      end
      if (e == 2) my_rd = 1'b0;
    end
    checks++;
    if (err_cnt != 1) begin
      errors++; $display("FAIL nosel_err_pulses got %0d exp 1", err_cnt);
    end
    idle(4);
  endtask

  task automatic test_timeout();
    int err_cnt  = 0;
    int err_edge = -1;
    int busy     = 0;
    reg1 = 8'h77; cs1 = 1'b1; my_rd = 1'b1;
    for (int e = 0; e <= 310; e++) begin
      @(negedge clk);
      if (rd_err === 1'b1) begin err_cnt++; err_edge = e; end
      if (e >= 264 && (data_oe !== 1'b0 || rd_ack !== 1'b0)) busy++;
      if (e == 4) begin
        checks++;
        if ({data_out, data_oe, rd_ack} !== {8'h77, 2'b11}) begin
          errors++; $display("FAIL to_start got %h/%b%b exp 77/11", data_out, data_oe, rd_ack);
        end
      end
      if (e == 258) begin
        checks++;
        if (rd_ack !== 1'b1) begin
          errors++; $display("FAIL to_ack_before got %b exp 1", rd_ack);
        end
      end
      if (e == 259) begin
        checks++;
        if ({data_oe, rd_ack} !== 2'b10) begin
          errors++; $display("FAIL to_hold got %b%b exp 10", data_oe, rd_ack);
        end
      end
      if (e == 262) begin
        checks++;
        if (data_oe !== 1'b1) begin
          errors++; $display("FAIL to_oe_hold got %b exp 1", data_oe);
        end
      end
      if (e == 299) my_rd = 1'b0;
    end
    checks++;
    if (err_cnt != 1 || err_edge != 259) begin
      errors++; $display("FAIL to_err got %0d pulses at e=%0d exp 1 at e=259", err_cnt, err_edge);
    end
    checks++;
    if (busy != 0) begin
      errors++; $display("FAIL to_no_reread got %0d busy clocks exp 0", busy);
    end
    reg1 = 8'h78; my_rd = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(negedge clk);
      if (e == 2) my_rd = 1'b0;
    end
    checks++;
    if ({data_out, data_oe} !== {8'h78, 1'b1}) begin
      errors++; $display("FAIL to_rearm got %h/%b exp 78/1", data_out, data_oe);
    end
    cs1 = 1'b0;
    idle(10);
  endtask

  task automatic test_reset_mid();
    int busy = 0;
    reg1 = 8'h42; cs1 = 1'b1; my_rd = 1'b1;
    idle(7);
    checks++;
    if ({data_oe, rd_ack} !== 2'b11) begin
      errors++; $display("FAIL rstmid_drive got %b%b exp 11", data_oe, rd_ack);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({data_out, data_oe, rd_ack, rd_err} !== 11'd0) begin
      errors++; $display("FAIL rstmid_async got %h/%b%b%b exp 00/000", data_out, data_oe, rd_ack, rd_err);
    end
    idle(2);
    rst = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (data_oe !== 1'b0 || rd_ack !== 1'b0) busy++;
    end
    checks++;
    if (busy != 0) begin
      errors++; $display("FAIL rstmid_held got %0d busy clocks exp 0", busy);
    end
    my_rd = 1'b0;
    idle(6);
    my_rd = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(negedge clk);
      if (e == 3) begin
        checks++;
        if (data_oe !== 1'b0) begin
          errors++; $display("FAIL rstmid_latency got %b exp 0", data_oe);
        end
      end
      if (e == 2) my_rd = 1'b0;
    end
    checks++;
    if ({data_out, data_oe} !== {8'h42, 1'b1}) begin
      errors++; $display("FAIL rstmid_reread got %h/%b exp 42/1", data_out, data_oe);
    end
    cs1 = 1'b0;
    idle(10);
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    reg2 = 8'hA5; cs2 = 1'b1; my_rd = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      @(negedge clk);
      exp_ack = (e == 4 || e == 9);
      if (e >= 4) begin
        checks++;
        if (data_oe !== (e <= 13)) begin
          errors++; $display("FAIL b2b_oe e=%0d got %b exp %b", e, data_oe, (e <= 13));
        end
        checks++;
        if (rd_ack !== exp_ack) begin
          errors++; $display("FAIL b2b_ack e=%0d got %b exp %b", e, rd_ack, exp_ack);
        end
      end
      if (e == 8) begin
        checks++;
        if (data_out !== 8'hA5) begin
          errors++; $display("FAIL b2b_first got %h exp a5", data_out);
        end
      end
      if (e == 9) begin
        checks++;
        if (data_out !== 8'h3C) begin
          errors++; $display("FAIL b2b_second got %h exp 3c", data_out);
        end
      end
      if (e == 2) my_rd = 1'b0;
      if (e == 4) begin my_rd = 1'b1; cs2 = 1'b0; cs3 = 1'b1; reg3 = 8'h3C; end
      if (e == 7) my_rd = 1'b0;
    end
    cs3 = 1'b0;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_priority();
    test_no_select();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
